// File: rtl/pipe_pkg.sv
// Shared types and constants for the in-order RV32 pipeline hazard logic.
//   sb_entry_t : one scoreboard slot {valid, we, load, rd}
//   FWD_RF     : forwarding select value meaning "use register-file data"
//   OPC_*      : RV32 base opcode encodings used by decode
package pipe_pkg;

    // rd is stored at a fixed maximum width so the struct can live in the
    // package; the top zero-extends its AW-bit register addresses into it.
    localparam int unsigned SB_AW_MAX = 8;

    localparam int unsigned FWD_RF = 0;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        logic                 valid;
        logic                 we;
        logic                 load;
        logic [SB_AW_MAX-1:0] rd;
    } sb_entry_t;

endpackage

// File: rtl/pipe_fwd_match.sv
// Priority search of the scoreboard for one source register.
//   entries : scoreboard, index 0 = youngest (EX)
//   rs      : source register address
//   used    : source is actually read
//   hit     : some in-flight entry writes rs (never for x0 or unused rs)
//   ready   : the youngest such writer already has its data
//   sel     : youngest writer index + 1 (0 when no hit)
module pipe_fwd_match
    import pipe_pkg::*;
#(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned LOAD_READY = 1,
    parameter int unsigned AW         = 5,
    parameter int unsigned SW         = $clog2(DEPTH + 1)
) (
    input  sb_entry_t [DEPTH-1:0] entries,
    input  logic [AW-1:0]         rs,
    input  logic                  used,
    output logic                  hit,
    output logic                  ready,
    output logic [SW-1:0]         sel
);

    always_comb begin
        hit   = 1'b0;
        ready = 1'b0;
        sel   = '0;
        // First match from the young end wins; older matches are ignored,
        // so a ready older writer can never hide an unready younger one.
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (!hit && used && (rs != '0) && entries[k].valid && entries[k].we &&
                (entries[k].rd == SB_AW_MAX'(rs))) begin
                hit   = 1'b1;
                ready = !entries[k].load || (k >= LOAD_READY);
                sel   = SW'(k + 1);
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard detection and operand forwarding for the in-order RV32 pipeline.
// Tracks in-flight writers in a DEPTH-entry shift register, forwards the
// youngest ready producer, stalls decode on load-use, kills the issue slot on
// a taken branch, and keeps saturating stall/flush cycle counters.
//   clk_i, rst_i           clock, synchronous active-high reset
//   issue_*                decode-stage instruction description
//   rs1/rs2_addr/used/rf   source addresses, usage flags, RF read data
//   stage_data_i           result per entry, slice k = entry k
//   flush_i                taken branch/jump this cycle
//   stall_o                hold PC and IF/DE, inject bubble
//   fwd_a/b_sel_o          0 = RF, k+1 = entry k
//   opa_o, opb_o           forwarded operands
//   stall_cnt_o/flush_cnt_o saturating perf counters
module pipe_hazard_unit
    import pipe_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned LOAD_READY = 1,
    parameter int unsigned CNT_W      = 32,
    localparam int unsigned AW        = $clog2(NUM_REGS),
    localparam int unsigned SW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  issue_valid_i,
    input  logic                  issue_we_i,
    input  logic                  issue_load_i,
    input  logic [AW-1:0]         issue_rd_i,
    input  logic [AW-1:0]         rs1_addr_i,
    input  logic [AW-1:0]         rs2_addr_i,
    input  logic                  rs1_used_i,
    input  logic                  rs2_used_i,
    input  logic [XLEN-1:0]       rs1_rf_i,
    input  logic [XLEN-1:0]       rs2_rf_i,
    input  logic [DEPTH*XLEN-1:0] stage_data_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic [SW-1:0]         fwd_a_sel_o,
    output logic [SW-1:0]         fwd_b_sel_o,
    output logic [XLEN-1:0]       opa_o,
    output logic [XLEN-1:0]       opb_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
);

    sb_entry_t [DEPTH-1:0] entries;

    logic          a_hit, a_ready, b_hit, b_ready;
    logic [SW-1:0] a_sel, b_sel;
    logic          issue_ok;

    pipe_fwd_match #(
        .DEPTH      (DEPTH),
        .LOAD_READY (LOAD_READY),
        .AW         (AW)
    ) u_match_a (
        .entries (entries),
        .rs      (rs1_addr_i),
        .used    (rs1_used_i),
        .hit     (a_hit),
        .ready   (a_ready),
        .sel     (a_sel)
    );

    pipe_fwd_match #(
        .DEPTH      (DEPTH),
        .LOAD_READY (LOAD_READY),
        .AW         (AW)
    ) u_match_b (
        .entries (entries),
        .rs      (rs2_addr_i),
        .used    (rs2_used_i),
        .hit     (b_hit),
        .ready   (b_ready),
        .sel     (b_sel)
    );

    // flush_i has priority: a wrong-path instruction never stalls or issues.
    always_comb begin
        stall_o     = issue_valid_i && !flush_i &&
                      ((a_hit && !a_ready) || (b_hit && !b_ready));
        issue_ok    = issue_valid_i && !stall_o && !flush_i;
        fwd_a_sel_o = (a_hit && a_ready) ? a_sel : SW'(FWD_RF);
        fwd_b_sel_o = (b_hit && b_ready) ? b_sel : SW'(FWD_RF);
    end

    always_comb begin
        opa_o = rs1_rf_i;
        opb_o = rs2_rf_i;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (fwd_a_sel_o == SW'(k + 1)) opa_o = stage_data_i[k*XLEN +: XLEN];
            if (fwd_b_sel_o == SW'(k + 1)) opb_o = stage_data_i[k*XLEN +: XLEN];
        end
    end

    // The retiring tail entry simply falls off, so an issue to the same rd
    // in that cycle is tracked only by the new entry 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            entries <= '0;
        end else begin
            for (int unsigned k = 1; k < DEPTH; k++) begin
                entries[k] <= entries[k-1];
            end
            if (issue_ok) begin
                entries[0] <= '{valid: 1'b1, we: issue_we_i, load: issue_load_i,
                                rd: SB_AW_MAX'(issue_rd_i)};
            end else begin
                entries[0] <= '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall_o && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + 1'b1;
            if (flush_i && (flush_cnt_o != '1)) flush_cnt_o <= flush_cnt_o + 1'b1;
        end
    end

endmodule
